// File: rtl/div_stall_unit.sv
// ---------------------------------------------------------------------------
// div_stall_unit
//
// Multi-cycle radix-2 restoring divider for the EX stage (DIV / DIVU). This
// unit asks the stall controller to stall the pipeline. It holds
// stallreq_for_ex high while a division is in flight. It drops the request in
// the same cycle that ready rises, so EX advances exactly once with a valid
// {remainder, quotient} pair for the HI/LO write path.
//
// Ports
//   clk             : rising-edge clock
//   rst             : synchronous, active-high reset
//   start           : EX holds a DIV/DIVU; held high until ready is seen
//   annul           : flush, abandon any operation in flight (beats start)
//   signed_div      : 1 = DIV (two's complement), 0 = DIVU
//   opdata1         : dividend, sampled only on acceptance
//   opdata2         : divisor, sampled only on acceptance
//   result          : {remainder, quotient}; upper half -> HI, lower -> LO
//   ready           : result valid (state END)
//   stallreq_for_ex : combinational stall request to the stall controller
//
// Timing, measured from the acceptance cycle (cycle 0):
//   nonzero divisor : ON in cycles 1..WIDTH, ready in cycle WIDTH+1
//   zero divisor    : BYZERO in cycle 1, ready in cycle 2, result = 0
// ---------------------------------------------------------------------------
module div_stall_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 annul,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stallreq_for_ex
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0]     dvd_q, dvd_d;     // dividend, turns into the quotient
    logic [WIDTH-1:0]     dvs_q, dvs_d;     // divisor magnitude
    logic                 qneg_q, qneg_d;   // negate quotient at the end
    logic                 rneg_q, rneg_d;   // negate remainder at the end
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    // -----------------------------------------------------------------------
    // Operand magnitudes. For DIV the operands are negated when negative.
    // |most negative| wraps to itself, and the unsigned path below reads
    // that as 2^(WIDTH-1), which is the value wanted.
    // -----------------------------------------------------------------------
    logic             sign1, sign2;
    logic [WIDTH-1:0] op1_abs, op2_abs;

    assign sign1   = signed_div & opdata1[WIDTH-1];
    assign sign2   = signed_div & opdata2[WIDTH-1];
    assign op1_abs = sign1 ? ({WIDTH{1'b0}} - opdata1) : opdata1;
    assign op2_abs = sign2 ? ({WIDTH{1'b0}} - opdata2) : opdata2;

    // -----------------------------------------------------------------------
    // One restoring step. {rem, dvd} shifts left by one. The divisor is then
    // trial-subtracted from the WIDTH+1-bit shifted remainder. Bit WIDTH of
    // the difference is the borrow: 0 means the subtraction fits.
    // rem < dvs always holds, so a kept difference fits in WIDTH bits.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign qbit     = ~trial[WIDTH];
    assign rem_step = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_step = {dvd_q[WIDTH-2:0], qbit};

    // Sign correction applied when the last step is loaded into result.
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    assign quo_final = qneg_q ? ({WIDTH{1'b0}} - quo_step) : quo_step;
    assign rem_final = rneg_q ? ({WIDTH{1'b0}} - rem_step) : rem_step;

    // -----------------------------------------------------------------------
    // State register (including the datapath registers)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            S_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                        dvd_d   = op1_abs;
                        dvs_d   = op2_abs;
                        qneg_d  = sign1 ^ sign2;
                        rneg_d  = sign1;
                        cnt_d   = '0;
                        rem_d   = '0;
                    end
                end
            end

            S_BYZERO: begin
                if (annul) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    state_d  = S_END;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end

            S_ON: begin
                if (annul) begin
                    // Flush drops the partial data. The next acceptance
                    // reloads every datapath register anyway.
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                    cnt_d    = '0;
                end else begin
                    rem_d = rem_step;
                    dvd_d = quo_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d  = S_END;
                        ready_d  = 1'b1;
                        result_d = {rem_final, quo_final};
                    end
                end
            end

            S_END: begin
                // While start stays high, a downstream stall is holding the
                // instruction in EX, so the result is kept stable.
                ready_d = 1'b1;
                if (!start || annul) begin
                    state_d  = S_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs. The stall request is combinational so it falls in the same
    // cycle that ready rises.
    // -----------------------------------------------------------------------
    always_comb begin
        stallreq_for_ex = start & ~annul & (state_q != S_END);
        ready           = ready_q;
        result          = result_q;
    end

endmodule

// File: tb/tb_div_stall_unit.sv
module tb_div_stall_unit;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic           annul;
    logic           signed_div;
    logic [W-1:0]   opdata1;
    logic [W-1:0]   opdata2;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stallreq_for_ex;

    int checks_cnt;
    int fail_cnt;

    div_stall_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .annul           (annul),
        .signed_div      (signed_div),
        .opdata1         (opdata1),
        .opdata2         (opdata2),
        .result          (result),
        .ready           (ready),
        .stallreq_for_ex (stallreq_for_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge. Outputs are sampled #1 later, well
    // away from the rising edge.
    // Runs one divide with start held until ready. It checks the stall on
    // every busy cycle, the latency, the result, and the hold behaviour.
    // Then it drops start and checks that ready and result clear.
    task automatic run_div(input string tag, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [63:0] exp_res,
                           input int exp_lat, input int hold);
        int cyc;
        int stall_cyc;
        logic bad_stall;
        logic [63:0] held;
        @(negedge clk);
        signed_div = s; opdata1 = a; opdata2 = b; start = 1'b1; annul = 1'b0;
        cyc = 0; stall_cyc = 0; bad_stall = 1'b0;
        #1;
        while (!ready) begin
            if (stallreq_for_ex) stall_cyc++;
            else bad_stall = 1'b1;
            cyc++;
            if (cyc > 200) break;
            @(negedge clk); #1;
        end
        check_val({tag, "_timeout"}, 64'(cyc > 200), 64'd0);
        check_val({tag, "_stall_gap"}, 64'(bad_stall), 64'd0);
        check_val({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check_val({tag, "_stall_cycles"}, 64'(stall_cyc), 64'(exp_lat));
        check_val({tag, "_stall_at_ready"}, 64'(stallreq_for_ex), 64'd0);
        check_val({tag, "_result"}, result, exp_res);
        $display("div %s signed=%0d a=%h b=%h result=%h latency=%0d", tag, s, a, b, result, cyc);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check_val({tag, "_hold_ready"}, 64'(ready), 64'd1);
            check_val({tag, "_hold_result"}, result, held);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); #1;
        check_val({tag, "_drop_ready"}, 64'(ready), 64'd0);
        check_val({tag, "_drop_result"}, result, 64'd0);
    endtask

    initial begin
        checks_cnt = 0; fail_cnt = 0;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_ready", 64'(ready), 64'd0);
        check_val("reset_result", result, 64'd0);
        check_val("reset_stall", 64'(stallreq_for_ex), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-computed results.
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 4);
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
        run_div("div_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 0);
        run_div("div_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33, 0);
        run_div("divu_big_2", 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33, 0);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 64'h0, 2, 1);
        run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 0);
        run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, 0);

        // Annul in cycle 10 after acceptance: the request drops immediately
        // and ready must never assert afterwards.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        #1;
        check_val("annul_stall", 64'(stallreq_for_ex), 64'd0);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                #1; if (ready) seen = 1'b1;
                @(negedge clk);
            end
            check_val("annul_no_ready", 64'(seen), 64'd0);
        end
        $display("annul of divu 100/7 in cycle 10 done");
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

        // Reset in cycle 5 of ON: the operation in flight is discarded.
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        check_val("rst_mid_ready", 64'(ready), 64'd0);
        check_val("rst_mid_result", result, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk); #1;
                if (ready) seen = 1'b1;
            end
            check_val("rst_mid_no_ready", 64'(seen), 64'd0);
        end
        $display("reset during divu 100/7 in cycle 5 done");
        run_div("divu_after_rst", 1'b0, 32'd100, 32'd10, 64'h00000000_0000000A, 33, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/div_stall_unit.md
Name: div_stall_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage; handles DIV/DIVU.
- It is the requesting side of the pipeline stall controller. While a division is in flight it drives stallreq_for_ex, which freezes IF/ID/EX.
- It releases the request once the remainder/quotient pair is ready for the HI/LO write path.
- The operation is held stable by EX while the stall is active.

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX holds a DIV/DIVU; held high until ready is seen.
- annul  input  1  flush: abandon any operation in flight.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1  input  WIDTH  dividend; sampled on acceptance only.
- opdata2  input  WIDTH  divisor; sampled on acceptance only.
- result  output  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO.
- ready  output  1  result valid (state END).
- stallreq_for_ex  output  1  stall request to the stall controller.

Behaviour:
- States: IDLE, BYZERO, ON, END. Registered state, counter, partial remainder, quotient, result and ready. stallreq_for_ex is combinational.
- Reset (rst=1 at a clock edge): state=IDLE, cnt=0, result=0, ready=0. Reset overrides all inputs, including mid-operation; any operation in flight is discarded.
- stallreq_for_ex = start & ~annul & (state != END). It drops in the same cycle ready rises, so EX advances exactly once with a valid result.
- IDLE:
  - start=1, annul=0, opdata2==0 → BYZERO.
  - start=1, annul=0, opdata2!=0 → ON. Latch |opdata1| and |opdata2| (absolute values only when signed_div=1). Latch quotient sign = sign1^sign2 and remainder sign = sign1. Clear cnt and partial remainder.
  - Otherwise stay in IDLE with ready=0.
- ON, one quotient bit per cycle:
  - Shift {rem, dvd} left by 1.
  - Trial-subtract the divisor from rem (WIDTH+1-bit subtract).
  - If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - cnt increments each cycle. After the cycle with cnt==WIDTH-1 → END.
  - On that edge, load result with sign correction: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
- BYZERO: next edge → END with result = 0.
- END:
  - ready=1, result held.
  - If start=0 or annul=1 → IDLE with ready=0 and result=0 on the next edge.
  - If start stays 1 (downstream stall), remain in END holding the result.
- annul=1 in ON or BYZERO → IDLE on the next edge, ready stays 0, partial data dropped. annul in IDLE blocks acceptance. annul has priority over start in the same cycle.
- Latency from the acceptance cycle (cycle 0):
  - Nonzero divisor: ON occupies cycles 1..WIDTH; ready=1 in cycle WIDTH+1 (33 for WIDTH=32). stallreq is high in cycles 0..WIDTH.
  - Zero divisor: ready in cycle 2; stallreq is high in cycles 0..1.
- Arithmetic:
  - Unsigned uses raw operands.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap, no trap).
  - |0x80000000| is treated as unsigned 0x80000000.
- Back-to-back: a new start is accepted only from IDLE. Since END returns to IDLE only after start falls, two consecutive divides have at least one idle cycle between them.

Test Plan:
- Unsigned: DIVU 100/7, start held → stallreq high 33 cycles; ready in cycle 33; result = {0x00000002, 0x0000000E}; stallreq low in that cycle.
- Signed: DIV -7/2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: DIVU 5/0 → BYZERO; ready in cycle 2; result = 0; stallreq high exactly 2 cycles.
- Overflow and unsigned extreme:
  - DIV 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}.
  - DIVU 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
- Annul mid-operation: annul pulse in cycle 10 of ON → IDLE next cycle; ready never asserts. A fresh DIVU 9/3 then completes with {0, 3}.
- Reset and hold:
  - rst asserted in cycle 5 of ON → next cycle state IDLE, ready=0, result=0.
  - Separately, start held 4 cycles past ready → result stable, ready=1 throughout. Start dropped → ready=0 next cycle.
